// File: rtl/pri_encoder_arb.sv
// N-to-log2(N) request encoder with a registered grant held under valid/ready.
// Selection is fixed priority (highest index wins) or round-robin from rr_ptr.
module pri_encoder_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic [W-1:0] rr_ptr
);

  if (W != $clog2(N)) begin : g_width_check
    $error("pri_encoder_arb: W must equal ceil(log2(N))");
  end
  if (N < 2 || N > 64) begin : g_range_check
    $error("pri_encoder_arb: N must be in 2..64");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state_q;
  logic [W-1:0] idx_q;
  logic [W-1:0] ptr_q;
  logic [N-1:0] onehot_q;
  logic         multi_q;

  logic         accept;
  logic         capture;
  logic [W-1:0] ptr_next;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] sel;
  logic [N-1:0] sel_onehot;
  logic         multi;

  assign accept   = (state_q == HOLD) && out_ready;
  assign capture  = (|req) && ((state_q == IDLE) || out_ready);
  assign ptr_next = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
  // The pointer produced by this cycle's accept is forwarded into the search
  assign ptr_eff  = accept ? ptr_next : ptr_q;
  assign multi    = |(req & (req - N'(1)));

  always_comb begin : sel_logic
    int unsigned  pos;
    logic         found;
    logic [W-1:0] p;
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    p     = '0;
    if (rr_en) begin
      for (int unsigned k = 0; k < N; k++) begin
        pos = 32'(ptr_eff) + k;
        if (pos >= N) pos = pos - N;
        p = W'(pos);
        if (!found && req[p]) begin
          sel   = p;
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[W'(i)]) sel = W'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_onehot[i] = (sel == W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      if (accept) ptr_q <= ptr_next;
      if (capture) begin
        state_q  <= HOLD;
        idx_q    <= sel;
        onehot_q <= sel_onehot;
        multi_q  <= multi;
      end else if (accept) begin
        state_q <= IDLE;
      end
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;
  assign rr_ptr     = ptr_q;

endmodule

// File: tb/tb_pri_encoder_arb.sv
// Directed bench for pri_encoder_arb: N=8 vector table plus N=5 wrap and async-reset sequences.
module tb_pri_encoder_arb;

  typedef struct {
    logic [7:0] req;
    logic       rr_en;
    logic       rdy;
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] eoh;
    logic       em;
    logic [2:0] eptr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic       rr8, rdy8;
  logic       v8, m8;
  logic [2:0] idx8, ptr8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       rr5, rdy5;
  logic       v5, m5;
  logic [2:0] idx5, ptr5;
  logic [4:0] oh5;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pri_encoder_arb #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr8), .out_ready(rdy8),
    .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .out_multi(m8), .rr_ptr(ptr8)
  );

  pri_encoder_arb #(.N(5), .W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .rr_en(rr5), .out_ready(rdy5),
    .out_valid(v5), .out_idx(idx5), .out_onehot(oh5), .out_multi(m5), .rr_ptr(ptr5)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic rr, input logic rdy, input logic ev,
                     input logic [2:0] ei, input logic [7:0] eo, input logic em, input logic [2:0] ep);
    vec_t v;
    v.req = r; v.rr_en = rr; v.rdy = rdy; v.ev = ev;
    v.eidx = ei; v.eoh = eo; v.em = em; v.eptr = ep;
    tbl.push_back(v);
  endtask

  task automatic chk8(input string tag, input logic ev, input logic [2:0] ei,
                      input logic [7:0] eo, input logic em, input logic [2:0] ep);
    chk({tag, " valid"}, 64'(v8), 64'(ev));
    chk({tag, " idx"}, 64'(idx8), 64'(ei));
    chk({tag, " onehot"}, 64'(oh8), 64'(eo));
    chk({tag, " multi"}, 64'(m8), 64'(em));
    chk({tag, " ptr"}, 64'(ptr8), 64'(ep));
  endtask

  task automatic chk5(input string tag, input logic ev, input logic [2:0] ei,
                      input logic [4:0] eo, input logic em, input logic [2:0] ep);
    chk({tag, " valid"}, 64'(v5), 64'(ev));
    chk({tag, " idx"}, 64'(idx5), 64'(ei));
    chk({tag, " onehot"}, 64'(oh5), 64'(eo));
    chk({tag, " multi"}, 64'(m5), 64'(em));
    chk({tag, " ptr"}, 64'(ptr5), 64'(ep));
  endtask

  initial begin
    logic [7:0] oh;
    // idle with no requests
    for (int i = 0; i < 5; i++) add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    // fixed priority: highest set bit of 0101_0010 is 6
    add(8'h52, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b1, 3'd0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 8'h40, 1'b1, 3'd7);
    // round-robin, all requesting
    add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7);
    for (int g = 0; g < 10; g++) begin
      oh = 8'h01 << (g % 8);
      add(8'hFF, 1'b1, 1'b1, 1'b1, 3'(g % 8), oh, 1'b1, 3'(g % 8));
    end
    add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2);
    add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3);
    // held grant frozen while req changes
    for (int i = 0; i < 4; i++) add(8'h80, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3);
    add(8'h80, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0, 3'd4);
    add(8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0, 3'd4);
    add(8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h80, 1'b0, 3'd0);
    add(8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 8'h80, 1'b0, 3'd0);
    // mixed modes, pointer forwarding and modulo wrap
    add(8'h0F, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1, 3'd0);
    add(8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 3'd4);
    add(8'h30, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10, 1'b1, 3'd1);
    add(8'h03, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1, 3'd5);
    add(8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 3'd1);
    add(8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0, 3'd1);
    add(8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h20, 1'b0, 3'd6);

    rst_n = 1'b0;
    req8 = '0; rr8 = 1'b0; rdy8 = 1'b0;
    req5 = '0; rr5 = 1'b0; rdy5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk8("reset8", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk5("reset5", 1'b0, 3'd0, 5'h00, 1'b0, 3'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[k]) begin
      req8 = tbl[k].req; rr8 = tbl[k].rr_en; rdy8 = tbl[k].rdy;
      @(posedge clk);
      #1;
      chk8($sformatf("step%0d", k), tbl[k].ev, tbl[k].eidx, tbl[k].eoh, tbl[k].em, tbl[k].eptr);
    end

    // async reset mid-hold discards grant and pointer without a clock edge
    req8 = 8'h20; rr8 = 1'b0; rdy8 = 1'b0;
    @(posedge clk);
    #1;
    chk8("prereset", 1'b1, 3'd5, 8'h20, 1'b0, 3'd6);
    #2 rst_n = 1'b0;
    #1;
    chk8("asyncrst", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    req8 = 8'h81; rr8 = 1'b1; rdy8 = 1'b1;
    @(posedge clk);
    #1;
    chk8("postrst", 1'b1, 3'd0, 8'h01, 1'b1, 3'd0);
    req8 = 8'h00;

    // N=5: pointer wraps 4 -> 0, never reaching 5..7
    req5 = 5'b01000; rr5 = 1'b1; rdy5 = 1'b1;
    @(posedge clk);
    #1;
    chk5("n5 g3", 1'b1, 3'd3, 5'b01000, 1'b0, 3'd0);
    req5 = 5'b10001;
    @(posedge clk);
    #1;
    chk5("n5 g4a", 1'b1, 3'd4, 5'b10000, 1'b1, 3'd4);
    @(posedge clk);
    #1;
    chk5("n5 g0", 1'b1, 3'd0, 5'b00001, 1'b1, 3'd0);
    @(posedge clk);
    #1;
    chk5("n5 g4b", 1'b1, 3'd4, 5'b10000, 1'b1, 3'd1);
    req5 = '0;
    @(posedge clk);
    #1;
    chk5("n5 idle", 1'b0, 3'd4, 5'b10000, 1'b1, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
